ctl_spi_regif: RTL and testbench
================================

Name: ctl_spi_regif

Overview:
- Control-SPI slave front end; sits directly downstream of the per-signal edge-refine filters on the ctl SPI pins.
- Consumes filtered sck/cs plus raw si, decodes a command/address/data byte protocol, and drives so.
- Presents a simple synchronous register-file port (write strobe, read request with 1-cycle read data) to the controller's register bank.
- SPI mode 0, MSB first; fully oversampled in the clk domain.

Parameters:
- ADDR_W, 7, register address width (command byte bits [6:0]); fixed by protocol, never wider than 7.
- DATA_W, 8, register data width; one SPI byte per register.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- spi_sck  input  1  filtered SPI clock, already synchronous to clk.
- spi_cs  input  1  filtered chip select, active low, already synchronous to clk.
- spi_si  input  1  raw MOSI; 2-flop synchronized internally.
- spi_so  output  1  MISO; driven 0 while not in a read data phase.
- wr_en  output  1  one-cycle write strobe.
- wr_addr  output  ADDR_W  write address, valid while wr_en=1.
- wr_data  output  DATA_W  write data, valid while wr_en=1.
- rd_en  output  1  one-cycle read request.
- rd_addr  output  ADDR_W  read address, valid while rd_en=1.
- rd_data  input  DATA_W  register data; valid exactly 1 clk after rd_en.
- busy  output  1  high while a transaction is active (state != IDLE).

Behaviour:
- Reset: all outputs 0; state IDLE; bit counter 0; address 0; the armed flag is cleared.
- Armed flag: set when spi_cs is sampled high. IDLE->CMD only on an spi_cs falling transition while armed. This ensures a reset released mid-transaction ignores that transaction.
- Edge detect: rise = spi_sck & ~sck_q; fall = ~spi_sck & sck_q. The si synchronizer is 2 flops; the upstream filter delay is >=3 clk, so si is stable at the sampled rise.
- Bit capture: on each rise, shift the synchronized si into the LSB of the rx shift register and increment the 3-bit counter. A byte is complete on the rise where the counter wraps 7->0.
- CMD state:
  - On byte complete, latch addr = rx[6:0].
  - If rx[7]=0, go to WDATA.
  - If rx[7]=1, go to RDATA and pulse rd_en with rd_addr=addr on the next clk.
- WDATA state:
  - On each byte complete, next clk: wr_en=1, wr_addr=addr, wr_data=rx byte.
  - Then addr increments.
- RDATA state:
  - The clk after rd_en, load the tx shift register from rd_data; spi_so = tx[7] combinationally from the register.
  - On each fall, shift tx left (fill 0).
  - On each byte complete, addr increments and a new rd_en for the new addr is issued.
  - The prefetched data loads into tx before the next fall. Requires the sck low phase to be >=3 clk.
  - si is ignored in RDATA.
- Address arithmetic: modulo 2^ADDR_W; 127 increments to 0 with no flag.
- cs deassert (rise of spi_cs) in any state:
  - Next clk: state IDLE, counter 0, tx cleared, spi_so=0.
  - A partial byte is discarded; no wr_en for it.
  - A wr_en/rd_en already scheduled for that same clk still issues.
- Simultaneous byte-complete and cs rise in the same clk: the byte counts as complete (strobe issued), then IDLE.
- cs low with no sck edges: hold state indefinitely; no timeout.
- Strobes: wr_en and rd_en are never both high; each is at most 1 clk wide.

Decomposition:
- Package ctl_spi_pkg holds:
  - state enum {IDLE, CMD, WDATA, RDATA};
  - CMD_RW_BIT=7;
  - ADDR_W/DATA_W defaults.
- One sub-module, ctl_spi_edge_det: 2-flop si synchronizer plus sck/cs edge detect, outputs rise, fall, cs_fall, cs_rise, si_s.
- The FSM, shift registers and address counter stay in ctl_spi_regif.

Test Plan:
- Write burst: cs low, send 0x05,0xA1,0xB2, cs high -> wr_en pulses twice: (addr 0x05, data 0xA1), then (0x06, 0xB2); busy falls 1 clk after cs rises.
- Read burst: model rd_data=addr^0x3C; send 0x90 then two dummy bytes -> rd_en for 0x10,0x11,0x12; so bytes 0x2C,0x2D; so=0 after cs high.
- Wrap: write command to addr 0x7F plus 2 data bytes -> wr_addr 0x7F then 0x00.
- Abort: cs high after 5 bits of a write data byte -> no wr_en; the next transaction decodes its command correctly.
- Reset mid-transaction: assert rst_n low during a read data byte, release with cs still low, continue clocking -> no strobes, so=0 until cs goes high then low again.
- Back-to-back: two transactions separated by 1 clk of cs high -> both decoded, addresses independent.

Source files
------------

// File: rtl/ctl_spi_pkg.sv
// Shared types and constants for the control-SPI register interface.
package ctl_spi_pkg;

   // Default register address width; the command byte carries at most 7 bits.
   localparam int unsigned ADDR_W_DEF = 7;

   // Default register data width; one SPI byte per register.
   localparam int unsigned DATA_W_DEF = 8;

   // Command byte bit selecting read (1) or write (0).
   localparam int unsigned CMD_RW_BIT = 7;

   // Transaction phase.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CMD   = 2'd1,
      WDATA = 2'd2,
      RDATA = 2'd3
   } state_e;

endpackage

// File: rtl/ctl_spi_edge_det.sv
// Edge detection for filtered sck/cs and a 2-flop synchronizer for raw si.
module ctl_spi_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic spi_sck_i,
   input  logic spi_cs_i,
   input  logic spi_si_i,
   output logic rise_o,
   output logic fall_o,
   output logic cs_fall_o,
   output logic cs_rise_o,
   output logic si_s_o
);

   logic sck_q;
   logic cs_q;
   logic si_meta_q;
   logic si_sync_q;

   // Remember last sck/cs levels; cs idles high so reset assumes deasserted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_q     <= 1'b0;
         cs_q      <= 1'b1;
         si_meta_q <= 1'b0;
         si_sync_q <= 1'b0;
      end else begin
         sck_q     <= spi_sck_i;
         cs_q      <= spi_cs_i;
         si_meta_q <= spi_si_i;
         si_sync_q <= si_meta_q;
      end
   end

   assign rise_o    =  spi_sck_i & ~sck_q;
   assign fall_o    = ~spi_sck_i &  sck_q;
   assign cs_fall_o = ~spi_cs_i  &  cs_q;
   assign cs_rise_o =  spi_cs_i  & ~cs_q;
   assign si_s_o    =  si_sync_q;

endmodule

// File: rtl/ctl_spi_regif.sv
// Control-SPI slave: decodes command/address/data bytes into register strobes.
module ctl_spi_regif
   import ctl_spi_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              spi_sck,
   input  logic              spi_cs,
   input  logic              spi_si,
   output logic              spi_so,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              busy
);

   logic rise;
   logic fall;
   logic cs_fall;
   logic cs_rise;
   logic si_s;

   state_e            state_q;
   logic              armed_q;
   logic [2:0]        cnt_q;
   logic [7:0]        rx_q;
   logic [7:0]        rx_d;
   logic [DATA_W-1:0] tx_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] addr_inc;
   logic              rd_pend_q;
   logic              byte_done;
   logic              wr_en_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [DATA_W-1:0] wr_data_q;
   logic              rd_en_q;
   logic [ADDR_W-1:0] rd_addr_q;

   ctl_spi_edge_det u_edge (
      .clk       (clk),
      .rst_n     (rst_n),
      .spi_sck_i (spi_sck),
      .spi_cs_i  (spi_cs),
      .spi_si_i  (spi_si),
      .rise_o    (rise),
      .fall_o    (fall),
      .cs_fall_o (cs_fall),
      .cs_rise_o (cs_rise),
      .si_s_o    (si_s)
   );

   assign rx_d      = {rx_q[6:0], si_s};
   assign byte_done = rise && (cnt_q == 3'd7);
   assign addr_inc  = addr_q + ADDR_W'(1);

   // Transaction FSM with bit counter, shift registers, address counter and strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         armed_q   <= 1'b0;
         cnt_q     <= 3'd0;
         rx_q      <= 8'd0;
         tx_q      <= '0;
         addr_q    <= '0;
         rd_pend_q <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
      end else begin
         wr_en_q   <= 1'b0;
         rd_en_q   <= 1'b0;
         rd_pend_q <= rd_en_q;
         armed_q   <= armed_q | spi_cs;
         case (state_q)
            IDLE: begin
               if (cs_fall && armed_q) begin
                  state_q <= CMD;
                  cnt_q   <= 3'd0;
               end
            end
            default: begin
               if (rise) begin
                  rx_q  <= rx_d;
                  cnt_q <= cnt_q + 3'd1;
               end
               if (byte_done) begin
                  case (state_q)
                     CMD: begin
                        addr_q <= rx_d[ADDR_W-1:0];
                        if (rx_d[CMD_RW_BIT]) begin
                           state_q   <= RDATA;
                           rd_en_q   <= 1'b1;
                           rd_addr_q <= rx_d[ADDR_W-1:0];
                        end else begin
                           state_q <= WDATA;
                        end
                     end
                     WDATA: begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= addr_q;
                        wr_data_q <= DATA_W'(rx_d);
                        addr_q    <= addr_inc;
                     end
                     default: begin
                        addr_q    <= addr_inc;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= addr_inc;
                     end
                  endcase
               end
               // The fall right after a byte boundary must not shift: the
               // prefetched byte lands around then and its MSB is next out.
               if (state_q == RDATA) begin
                  if (rd_pend_q) begin
                     tx_q <= rd_data;
                  end else if (fall && (cnt_q != 3'd0)) begin
                     tx_q <= {tx_q[DATA_W-2:0], 1'b0};
                  end
               end
               if (cs_rise) begin
                  state_q <= IDLE;
                  cnt_q   <= 3'd0;
                  tx_q    <= '0;
               end
            end
         endcase
      end
   end

   assign spi_so  = (state_q == RDATA) & tx_q[DATA_W-1];
   assign busy    = (state_q != IDLE);
   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign rd_en   = rd_en_q;
   assign rd_addr = rd_addr_q;

endmodule

// File: tb/tb_ctl_spi_regif.sv
// Scoreboarded random/directed bench for the control-SPI register interface.
module tb_ctl_spi_regif;

   localparam int HP = 4;

   logic       clk = 1'b0;
   logic       rstN = 1'b0;
   logic       spiSck = 1'b0;
   logic       spiCs = 1'b1;
   logic       spiSi = 1'b0;
   logic       spiSo;
   logic       wrEn;
   logic [6:0] wrAddr;
   logic [7:0] wrData;
   logic       rdEn;
   logic [6:0] rdAddr;
   logic [7:0] rdData = 8'd0;
   logic       busy;

   typedef struct packed {
      logic [6:0] addr;
      logic [7:0] data;
   } wrExp_t;

   wrExp_t     wrQ[$];
   logic [6:0] rdQ[$];
   logic [7:0] bankMem[128];
   logic [7:0] refMem[128];
   int         testsRun = 0;
   int         testsFailed = 0;

   always #5 clk = ~clk;

   ctl_spi_regif dut (
      .clk     (clk),
      .rst_n   (rstN),
      .spi_sck (spiSck),
      .spi_cs  (spiCs),
      .spi_si  (spiSi),
      .spi_so  (spiSo),
      .wr_en   (wrEn),
      .wr_addr (wrAddr),
      .wr_data (wrData),
      .rd_en   (rdEn),
      .rd_addr (rdAddr),
      .rd_data (rdData),
      .busy    (busy)
   );

   // Compare one value and log a failure line if it differs.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Register bank: 1-cycle read latency, writes from DUT strobes.
   initial begin
      for (int a = 0; a < 128; a++) bankMem[a] = 8'(a) ^ 8'h3C;
      forever begin
         @(posedge clk);
         if (rdEn) rdData <= bankMem[rdAddr];
         if (wrEn) bankMem[wrAddr] <= wrData;
      end
   end

   // Monitor: pops expected strobes whenever the DUT presents one.
   initial begin
      logic   prevWr;
      logic   prevRd;
      wrExp_t e;
      prevWr = 1'b0;
      prevRd = 1'b0;
      forever begin
         @(negedge clk);
         if (rstN) begin
            if (wrEn || rdEn) checkOutput("strobe_exclusive", 32'(wrEn & rdEn), 32'd0);
            if (wrEn) begin
               checkOutput("wr_width", 32'(prevWr), 32'd0);
               if (wrQ.size() == 0) begin
                  checkOutput("wr_unexpected", {17'd0, wrAddr, wrData}, 32'hFFFF_FFFF);
               end else begin
                  e = wrQ.pop_front();
                  checkOutput("wr_addr", 32'(wrAddr), 32'(e.addr));
                  checkOutput("wr_data", 32'(wrData), 32'(e.data));
               end
            end
            if (rdEn) begin
               checkOutput("rd_width", 32'(prevRd), 32'd0);
               if (rdQ.size() == 0) begin
                  checkOutput("rd_unexpected", 32'(rdAddr), 32'hFFFF_FFFF);
               end else begin
                  checkOutput("rd_addr", 32'(rdAddr), 32'(rdQ.pop_front()));
               end
            end
         end
         prevWr = wrEn;
         prevRd = rdEn;
      end
   end

   // Safety net so the run always ends.
   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic waitClk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Mode 0 master: drive si while sck low, sample so just before each rise.
   task automatic applyStimulus(input logic [7:0] b, input int nBits, output logic [7:0] got);
      got = 8'd0;
      for (int i = 7; i >= 8 - nBits; i--) begin
         spiSi = b[i];
         waitClk(HP);
         got[i] = spiSo;
         spiSck = 1'b1;
         waitClk(HP);
         spiSck = 1'b0;
      end
      spiSi = 1'b0;
   endtask

   task automatic csStart();
      spiCs = 1'b0;
      waitClk(HP);
   endtask

   task automatic csEnd(input int gap);
      waitClk(2);
      checkOutput("busy_active", 32'(busy), 32'd1);
      spiCs = 1'b1;
      waitClk(1);
      checkOutput("busy_after_cs", 32'(busy), 32'd0);
      checkOutput("so_after_cs", 32'(spiSo), 32'd0);
      if (gap > 1) waitClk(gap - 1);
   endtask

   // Write burst: expected strobes come from the address/data sequence.
   task automatic doWrite(input logic [6:0] a, input int n, input logic [31:0] dw, input int gap);
      logic [7:0] got;
      logic [7:0] d;
      logic [6:0] ak;
      csStart();
      applyStimulus({1'b0, a}, 8, got);
      for (int k = 0; k < n; k++) begin
         ak = a + 7'(k);
         d = dw[31 - 8 * k -: 8];
         wrQ.push_back('{addr: ak, data: d});
         refMem[ak] = d;
         applyStimulus(d, 8, got);
      end
      csEnd(gap);
   endtask

   // Read burst: one request per byte plus the prefetch after the last one.
   task automatic doRead(input logic [6:0] a, input int n, input int gap);
      logic [7:0] got;
      logic [6:0] ak;
      csStart();
      rdQ.push_back(a);
      applyStimulus({1'b1, a}, 8, got);
      for (int k = 0; k < n; k++) begin
         ak = a + 7'(k);
         rdQ.push_back(ak + 7'd1);
         applyStimulus(8'($urandom), 8, got);
         checkOutput("so_byte", 32'(got), 32'(refMem[ak]));
      end
      csEnd(gap);
   endtask

   initial begin
      logic [7:0] got;
      for (int a = 0; a < 128; a++) refMem[a] = 8'(a) ^ 8'h3C;

      // Reset values.
      waitClk(3);
      checkOutput("rst_wr_en", 32'(wrEn), 32'd0);
      checkOutput("rst_rd_en", 32'(rdEn), 32'd0);
      checkOutput("rst_so", 32'(spiSo), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_wr_addr", 32'(wrAddr), 32'd0);
      checkOutput("rst_wr_data", 32'(wrData), 32'd0);
      checkOutput("rst_rd_addr", 32'(rdAddr), 32'd0);
      rstN = 1'b1;
      waitClk(3);
      checkOutput("idle_busy", 32'(busy), 32'd0);

      // Write burst, read burst, address wrap.
      doWrite(7'h05, 2, 32'hA1B2_0000, 4);
      checkOutput("bank_05", 32'(refMem[7'h05]), 32'hA1);
      doRead(7'h10, 2, 4);
      doWrite(7'h7F, 2, 32'h5AC3_0000, 4);
      doRead(7'h7F, 2, 4);

      // Abort mid data byte: no write, then a clean transaction.
      csStart();
      applyStimulus(8'h20, 8, got);
      applyStimulus(8'hE7, 5, got);
      csEnd(4);
      doWrite(7'h21, 1, 32'h9600_0000, 4);
      doRead(7'h20, 2, 4);

      // Reset during a read data byte, released with cs still low.
      csStart();
      rdQ.push_back(7'h30);
      applyStimulus(8'hB0, 8, got);
      applyStimulus(8'hFF, 3, got);
      rstN = 1'b0;
      waitClk(2);
      rstN = 1'b1;
      waitClk(2);
      applyStimulus(8'hFF, 8, got);
      checkOutput("rst_mid_so", 32'(got), 32'd0);
      applyStimulus(8'h81, 8, got);
      checkOutput("rst_mid_so2", 32'(got), 32'd0);
      checkOutput("rst_mid_busy", 32'(busy), 32'd0);
      spiCs = 1'b1;
      waitClk(3);
      doRead(7'h31, 1, 4);

      // Back-to-back transactions with one clock of cs high.
      doWrite(7'h33, 1, 32'h1E00_0000, 1);
      doRead(7'h44, 1, 1);
      doWrite(7'h45, 2, 32'h0102_0000, 4);

      // Randomized transactions against the reference memory.
      for (int t = 0; t < 24; t++) begin
         logic [6:0] ra;
         int         rn;
         ra = 7'($urandom);
         rn = int'($urandom_range(1, 4));
         if ($urandom_range(0, 1) == 1)
            doWrite(ra, rn, $urandom, int'($urandom_range(1, 6)));
         else
            doRead(ra, rn, int'($urandom_range(1, 6)));
      end

      waitClk(10);
      checkOutput("wr_queue_drained", 32'(wrQ.size()), 32'd0);
      checkOutput("rd_queue_drained", 32'(rdQ.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
